// File: rtl/kb_tape_scan.sv
// ============================================================================
//  Module   : kb_tape_scan
//  Purpose  : Keyboard / tape front end. Synchronises and debounces a
//             ROWSxCOLS key matrix, answers row-select reads with debounced
//             column data and stretches tape activity with a retriggerable
//             monostable. Optional key-change event queue (valid/ready).
//  Ports    : clk        - system clock
//             rst_n      - asynchronous reset, active low
//             keycaps    - raw switches, 1=pressed, index r*COLS+c
//             row_sel_n  - row drive, 0=row selected
//             tape_in    - quantised tape signal (asynchronous)
//             dout       - {tape_s, nq, 1'b1, cols[COLS-1:0]}
//             evt_valid  - event available          (KBT_KEY_EVENT_EN only)
//             evt_ready  - consumer accepts event   (KBT_KEY_EVENT_EN only)
//             evt_code   - {press, key_idx[6:0]}    (KBT_KEY_EVENT_EN only)
//  Options  : define KBT_KEY_EVENT_EN to build the key event queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kb_tape_scan #(
  parameter int ROWS        = 8,
  parameter int COLS        = 5,
  parameter int HOLD_CCOUNT = 1198,
  parameter int TICK_DIV    = 3250,
  parameter int DB_SAMPLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ROWS*COLS-1:0]   keycaps,
  input  logic [ROWS-1:0]        row_sel_n,
  input  logic                   tape_in,
  output logic [COLS+2:0]        dout
`ifdef KBT_KEY_EVENT_EN
  ,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [7:0]             evt_code
`endif
);

  localparam int c_NKEYS = ROWS * COLS;
  localparam int c_PW    = $clog2(TICK_DIV);
  localparam int c_CW    = $clog2(DB_SAMPLES + 1);
  localparam int c_HW    = $clog2(HOLD_CCOUNT + 1);

  // --------------------------------------------------------------------------
  // Two-flop synchronisers for the key matrix and the tape input
  // --------------------------------------------------------------------------
  logic [c_NKEYS-1:0] key_s1_q, key_s2_q;
  logic               tape_s1_q, tape_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      tape_s1_q <= 1'b0;
      tape_s2_q <= 1'b0;
    end else begin
      key_s1_q  <= keycaps;
      key_s2_q  <= key_s1_q;
      tape_s1_q <= tape_in;
      tape_s2_q <= tape_s1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce sample prescaler: one tick per TICK_DIV cycles
  // --------------------------------------------------------------------------
  logic [c_PW-1:0] pre_q, pre_d;
  logic            w_tick;

  assign w_tick = (pre_q == c_PW'(TICK_DIV - 1));
  assign pre_d  = w_tick ? '0 : pre_q + c_PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end

  // --------------------------------------------------------------------------
  // Per-key debounce. A key flips only after DB_SAMPLES consecutive ticks in
  // which the synchronised level disagrees; one agreeing tick resets credit.
  // --------------------------------------------------------------------------
  logic [c_NKEYS-1:0]            key_stable_q, key_stable_d;
  logic [c_NKEYS-1:0][c_CW-1:0]  cnt_q, cnt_d;

  always_comb begin
    key_stable_d = key_stable_q;
    cnt_d        = cnt_q;
    if (w_tick) begin
      for (int k = 0; k < c_NKEYS; k++) begin
        if (key_s2_q[k] != key_stable_q[k]) begin
          if (cnt_q[k] + c_CW'(1) == c_CW'(DB_SAMPLES)) begin
            key_stable_d[k] = ~key_stable_q[k];
            cnt_d[k]        = '0;
          end else begin
            cnt_d[k] = cnt_q[k] + c_CW'(1);
          end
        end else begin
          cnt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_stable_q <= '0;
      cnt_q        <= '0;
    end else begin
      key_stable_q <= key_stable_d;
      cnt_q        <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Column read-back: open-collector style wired-AND over selected rows
  // --------------------------------------------------------------------------
  logic [COLS-1:0] w_cols;

  always_comb begin
    w_cols = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        w_cols[c] = w_cols[c] & (row_sel_n[r] | ~key_stable_q[r*COLS + c]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Retriggerable monostable on the synchronised tape level
  // --------------------------------------------------------------------------
  logic [c_HW-1:0] hold_ttl_q, hold_ttl_d;
  logic            w_nq;

  always_comb begin
    if (tape_s2_q)               hold_ttl_d = c_HW'(HOLD_CCOUNT);
    else if (hold_ttl_q != '0)   hold_ttl_d = hold_ttl_q - c_HW'(1);
    else                         hold_ttl_d = hold_ttl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_ttl_q <= '0;
    else        hold_ttl_q <= hold_ttl_d;
  end

  assign w_nq = (hold_ttl_q == '0);
  assign dout = {tape_s2_q, w_nq, 1'b1, w_cols};

`ifdef KBT_KEY_EVENT_EN
  // --------------------------------------------------------------------------
  // Key change event queue: one pending bit per key, single output register.
  // Repeated flips before reporting collapse; the code carries the state at
  // load time. A flip landing on the clearing cycle keeps the bit set.
  // --------------------------------------------------------------------------
  if (c_NKEYS > 128) begin : g_evt_size_chk
    $error("kb_tape_scan: ROWS*COLS must be <= 128 for key events");
  end

  logic [c_NKEYS-1:0] pend_q, pend_d, w_clr, w_flip;
  logic               evt_valid_q, evt_valid_d;
  logic [7:0]         evt_code_q, evt_code_d;
  logic               w_found;

  assign w_flip = key_stable_d ^ key_stable_q;

  always_comb begin
    w_clr       = '0;
    w_found     = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    if (!evt_valid_q || evt_ready) begin
      evt_valid_d = 1'b0;
      for (int k = 0; k < c_NKEYS; k++) begin
        if (!w_found && pend_q[k]) begin
          w_found     = 1'b1;
          w_clr[k]    = 1'b1;
          evt_code_d  = {key_stable_q[k], 7'(k)};
          evt_valid_d = 1'b1;
        end
      end
    end
    pend_d = (pend_q & ~w_clr) | w_flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
`endif

endmodule

`default_nettype wire
